// File: rtl/stage_mem.sv
// MEM pipeline stage: holds the EX result, waits for the data SRAM response of
// loads/stores, extracts load data and feeds WB plus the ID bypass network.
module stage_mem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        allowout,
    input  logic        validin,
    output logic        allowin,
    output logic        validout,
    input  logic [31:0] input_pc,
    output logic [31:0] output_pc,
    input  logic [4:0]  input_rf_waddr,
    input  logic        input_rf_we,
    input  logic [31:0] input_alu_result,
    input  logic        input_mem_req,
    input  logic [2:0]  input_load_op,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [4:0]  output_rf_waddr,
    output logic        output_rf_we,
    output logic [31:0] output_rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_waddr,
    output logic [31:0] fwd_wdata,
    output logic        fwd_pending
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic        valid;
    logic [31:0] pc_r;
    logic [4:0]  waddr_r;
    logic        rf_we_r;
    logic [31:0] alu_r;
    logic        mem_req_r;
    logic [2:0]  load_op_r;
    logic [31:0] buf_r;

    logic        readygo;
    logic        flush;
    logic        capture;
    logic        is_load;
    logic [31:0] src;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] wdata;

    assign readygo  = !mem_req_r || (state == S_HOLD) ||
                      (state == S_WAIT && data_sram_data_ok);
    assign validout = valid && readygo;
    assign allowin  = !valid || (readygo && allowout);
    assign flush    = validin && allowin;
    // A response that WB cannot take this cycle must be parked, since the SRAM
    // only presents rdata for the single data_ok cycle.
    assign capture  = (state == S_WAIT) && data_sram_data_ok && !allowout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            valid     <= 1'b0;
            pc_r      <= 32'h0;
            waddr_r   <= 5'h0;
            rf_we_r   <= 1'b0;
            alu_r     <= 32'h0;
            mem_req_r <= 1'b0;
            load_op_r <= 3'h0;
            buf_r     <= 32'h0;
        end else begin
            state <= state_nxt;
            if (allowin) begin
                valid <= validin;
            end
            if (flush) begin
                pc_r      <= input_pc;
                waddr_r   <= input_rf_waddr;
                rf_we_r   <= input_rf_we;
                alu_r     <= input_alu_result;
                mem_req_r <= input_mem_req;
                load_op_r <= input_load_op;
            end
            if (capture) begin
                buf_r <= data_sram_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush && input_mem_req) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    if (allowout) begin
                        state_nxt = (flush && input_mem_req) ? S_WAIT : S_IDLE;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (allowout) begin
                    state_nxt = (flush && input_mem_req) ? S_WAIT : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        src      = (state == S_HOLD) ? buf_r : data_sram_rdata;
        byte_sel = 8'h0;
        half_sel = alu_r[1] ? src[31:16] : src[15:0];
        is_load  = 1'b0;
        wdata    = alu_r;
        case (alu_r[1:0])
            2'd0:    byte_sel = src[7:0];
            2'd1:    byte_sel = src[15:8];
            2'd2:    byte_sel = src[23:16];
            default: byte_sel = src[31:24];
        endcase
        case (load_op_r)
            3'd1: begin is_load = 1'b1; wdata = {{24{byte_sel[7]}}, byte_sel}; end
            3'd2: begin is_load = 1'b1; wdata = {{16{half_sel[15]}}, half_sel}; end
            3'd3: begin is_load = 1'b1; wdata = src; end
            3'd4: begin is_load = 1'b1; wdata = {24'h0, byte_sel}; end
            3'd5: begin is_load = 1'b1; wdata = {16'h0, half_sel}; end
            default: begin is_load = 1'b0; wdata = alu_r; end
        endcase
    end

    assign output_pc       = pc_r;
    assign output_rf_waddr = waddr_r;
    assign output_rf_we    = validout && rf_we_r;
    assign output_rf_wdata = wdata;
    assign fwd_valid       = valid && rf_we_r && (waddr_r != 5'd0);
    assign fwd_waddr       = waddr_r;
    assign fwd_wdata       = wdata;
    assign fwd_pending     = fwd_valid && is_load && !readygo;

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: vector table, multi-cycle corner cases
// and a randomized run against a transaction-level reference model.
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        allowout, validin, allowin, validout;
    logic [31:0] input_pc, output_pc;
    logic [4:0]  input_rf_waddr, output_rf_waddr, fwd_waddr;
    logic        input_rf_we, output_rf_we;
    logic [31:0] input_alu_result;
    logic        input_mem_req;
    logic [2:0]  input_load_op;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [31:0] output_rf_wdata, fwd_wdata;
    logic        fwd_valid, fwd_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_mem dut (
        .clk(clk), .rst_n(rst_n), .allowout(allowout), .validin(validin),
        .allowin(allowin), .validout(validout),
        .input_pc(input_pc), .output_pc(output_pc),
        .input_rf_waddr(input_rf_waddr), .input_rf_we(input_rf_we),
        .input_alu_result(input_alu_result), .input_mem_req(input_mem_req),
        .input_load_op(input_load_op),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .output_rf_waddr(output_rf_waddr), .output_rf_we(output_rf_we),
        .output_rf_wdata(output_rf_wdata),
        .fwd_valid(fwd_valid), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending)
    );

    typedef struct {
        logic [2:0]  op;
        logic        mreq;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[11];

    // Reference model: one resident instruction plus whether its data arrived.
    logic        m_valid, m_we, m_mreq, m_has;
    logic [31:0] m_pc, m_alu, m_data;
    logic [4:0]  m_wa;
    logic [2:0]  m_op;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic vin, input logic aout,
                                 input logic dok, input logic [31:0] rd);
        validin           = vin;
        allowout          = aout;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
    endtask

    task automatic setInstr(input logic [31:0] pc, input logic [4:0] wa, input logic we,
                            input logic [31:0] alu, input logic mreq, input logic [2:0] op);
        input_pc         = pc;
        input_rf_waddr   = wa;
        input_rf_we      = we;
        input_alu_result = alu;
        input_mem_req    = mreq;
        input_load_op    = op;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic isLoadOp(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

    function automatic logic [31:0] refData(input logic [2:0] op, input logic [31:0] alu,
                                            input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> ({30'h0, alu[1:0]} * 8)) & 32'hFF;
        h = (word >> ({31'h0, alu[1]} * 16)) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            3'd3:    return word;
            3'd4:    return b;
            3'd5:    return h;
            default: return alu;
        endcase
    endfunction

    initial begin
        logic        ready, exp_pend, exp_ai;
        logic        r_vin, r_aout, r_dok;
        logic [31:0] r_rd, exp_w, exp_pc;

        vecs[0]  = '{3'd0, 1'b0, 1'b1, 5'd5,  32'h12345678, 32'h00000000, 32'h12345678};
        vecs[1]  = '{3'd1, 1'b1, 1'b1, 5'd6,  32'h10000002, 32'h00800000, 32'hFFFFFF80};
        vecs[2]  = '{3'd4, 1'b1, 1'b1, 5'd6,  32'h10000002, 32'h00800000, 32'h00000080};
        vecs[3]  = '{3'd5, 1'b1, 1'b1, 5'd7,  32'h10000002, 32'hBEEF1234, 32'h0000BEEF};
        vecs[4]  = '{3'd2, 1'b1, 1'b1, 5'd7,  32'h10000002, 32'hBEEF1234, 32'hFFFFBEEF};
        vecs[5]  = '{3'd3, 1'b1, 1'b1, 5'd8,  32'h10000003, 32'hBEEF1234, 32'hBEEF1234};
        vecs[6]  = '{3'd1, 1'b1, 1'b1, 5'd9,  32'h10000000, 32'h1234567F, 32'h0000007F};
        vecs[7]  = '{3'd2, 1'b1, 1'b1, 5'd10, 32'h10000001, 32'h80017FFF, 32'h00007FFF};
        vecs[8]  = '{3'd4, 1'b1, 1'b1, 5'd11, 32'h10000003, 32'hAB000000, 32'h000000AB};
        vecs[9]  = '{3'd0, 1'b1, 1'b0, 5'd0,  32'h20000010, 32'h77777777, 32'h20000010};
        vecs[10] = '{3'd6, 1'b0, 1'b1, 5'd12, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5};

        rst_n = 1'b0;
        setInstr(32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        checkOutput("reset_validout", {31'h0, validout}, 32'h0);
        checkOutput("reset_allowin", {31'h0, allowin}, 32'h1);
        checkOutput("reset_rf_we", {31'h0, output_rf_we}, 32'h0);
        checkOutput("reset_fwd_valid", {31'h0, fwd_valid}, 32'h0);
        checkOutput("reset_fwd_pending", {31'h0, fwd_pending}, 32'h0);
        checkOutput("reset_pc", output_pc, 32'h0);
        #11 rst_n = 1'b1;
        nextCycle();

        // Single-instruction vectors; memory ops respond two cycles after entry.
        for (int i = 0; i < 11; i++) begin
            exp_pc   = 32'h1c000000 + 32'(i) * 4;
            exp_pend = vecs[i].we && (vecs[i].wa != 5'd0) && isLoadOp(vecs[i].op);
            setInstr(exp_pc, vecs[i].wa, vecs[i].we, vecs[i].alu, vecs[i].mreq, vecs[i].op);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            nextCycle();
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            #1;
            checkOutput("vec_pc", output_pc, exp_pc);
            checkOutput("vec_waddr", {27'h0, output_rf_waddr}, {27'h0, vecs[i].wa});
            if (vecs[i].mreq) begin
                checkOutput("vec_wait_validout", {31'h0, validout}, 32'h0);
                checkOutput("vec_wait_pending", {31'h0, fwd_pending}, {31'h0, exp_pend});
                nextCycle();
                #1;
                checkOutput("vec_wait2_validout", {31'h0, validout}, 32'h0);
                checkOutput("vec_wait2_pending", {31'h0, fwd_pending}, {31'h0, exp_pend});
                applyStimulus(1'b0, 1'b1, 1'b1, vecs[i].rdata);
                #1;
            end
            checkOutput("vec_validout", {31'h0, validout}, 32'h1);
            checkOutput("vec_wdata", output_rf_wdata, vecs[i].exp_wdata);
            checkOutput("vec_fwd_wdata", fwd_wdata, vecs[i].exp_wdata);
            checkOutput("vec_rf_we", {31'h0, output_rf_we}, {31'h0, vecs[i].we});
            checkOutput("vec_fwd_valid", {31'h0, fwd_valid},
                        {31'h0, vecs[i].we && (vecs[i].wa != 5'd0)});
            checkOutput("vec_pending_clear", {31'h0, fwd_pending}, 32'h0);
            nextCycle();
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            #1;
            checkOutput("vec_drained", {31'h0, validout}, 32'h0);
            checkOutput("vec_allowin", {31'h0, allowin}, 32'h1);
        end

        // Stall capture: response arrives while WB is blocked, rdata then changes.
        setInstr(32'h1c000100, 5'd7, 1'b1, 32'h10000004, 1'b1, 3'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        #1;
        checkOutput("stall_first_validout", {31'h0, validout}, 32'h1);
        checkOutput("stall_first_wdata", output_rf_wdata, 32'hCAFEF00D);
        checkOutput("stall_first_allowin", {31'h0, allowin}, 32'h0);
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'(k == 1), (k == 1) ? 32'hDEADBEEF : 32'h0);
            #1;
            checkOutput("stall_hold_validout", {31'h0, validout}, 32'h1);
            checkOutput("stall_hold_wdata", output_rf_wdata, 32'hCAFEF00D);
            checkOutput("stall_hold_allowin", {31'h0, allowin}, 32'h0);
            checkOutput("stall_hold_pending", {31'h0, fwd_pending}, 32'h0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("stall_release_validout", {31'h0, validout}, 32'h1);
        checkOutput("stall_release_allowin", {31'h0, allowin}, 32'h1);
        checkOutput("stall_release_wdata", output_rf_wdata, 32'hCAFEF00D);
        nextCycle();
        #1;
        checkOutput("stall_after_validout", {31'h0, validout}, 32'h0);

        // Back-to-back loads: second flushes on the cycle of the first's response.
        setInstr(32'h1c000200, 5'd3, 1'b1, 32'h10000000, 1'b1, 3'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        setInstr(32'h1c000204, 5'd4, 1'b1, 32'h10000001, 1'b1, 3'd4);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h11111111);
        #1;
        checkOutput("b2b_first_validout", {31'h0, validout}, 32'h1);
        checkOutput("b2b_first_wdata", output_rf_wdata, 32'h11111111);
        checkOutput("b2b_first_pc", output_pc, 32'h1c000200);
        checkOutput("b2b_first_allowin", {31'h0, allowin}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("b2b_second_wait", {31'h0, validout}, 32'h0);
        checkOutput("b2b_second_pending", {31'h0, fwd_pending}, 32'h1);
        checkOutput("b2b_second_pc", output_pc, 32'h1c000204);
        nextCycle();
        #1;
        checkOutput("b2b_second_wait2", {31'h0, validout}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000AB00);
        #1;
        checkOutput("b2b_second_validout", {31'h0, validout}, 32'h1);
        checkOutput("b2b_second_wdata", output_rf_wdata, 32'h000000AB);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("b2b_drained", {31'h0, validout}, 32'h0);

        // Asynchronous reset while a load is waiting and its data is on the bus.
        setInstr(32'h1c000300, 5'd9, 1'b1, 32'h10000008, 1'b1, 3'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("areset_pre_pending", {31'h0, fwd_pending}, 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h5555AAAA);
        #1;
        checkOutput("areset_pre_validout", {31'h0, validout}, 32'h1);
        checkOutput("areset_pre_rf_we", {31'h0, output_rf_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("areset_validout", {31'h0, validout}, 32'h0);
        checkOutput("areset_rf_we", {31'h0, output_rf_we}, 32'h0);
        checkOutput("areset_fwd_valid", {31'h0, fwd_valid}, 32'h0);
        checkOutput("areset_allowin", {31'h0, allowin}, 32'h1);
        checkOutput("areset_pc", output_pc, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1 rst_n = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h12345678);
        #1;
        checkOutput("spurious_validout", {31'h0, validout}, 32'h0);
        checkOutput("spurious_allowin", {31'h0, allowin}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("spurious_after_validout", {31'h0, validout}, 32'h0);
        checkOutput("spurious_after_fwd_valid", {31'h0, fwd_valid}, 32'h0);
        nextCycle();

        // Randomized run against the reference model, starting from the reset state.
        m_valid = 1'b0; m_we = 1'b0; m_mreq = 1'b0; m_has = 1'b0;
        m_pc = 32'h0; m_alu = 32'h0; m_data = 32'h0; m_wa = 5'h0; m_op = 3'h0;
        for (int n = 0; n < 600; n++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            setInstr($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                     $urandom, isLoadOp(op) ? 1'b1 : 1'($urandom_range(0, 1)), op);
            r_vin  = 1'($urandom_range(0, 1));
            r_aout = 1'($urandom_range(0, 3) != 0);
            r_dok  = 1'($urandom_range(0, 1));
            r_rd   = $urandom;
            applyStimulus(r_vin, r_aout, r_dok, r_rd);
            #1;
            ready    = !m_mreq || m_has || r_dok;
            exp_ai   = !m_valid || (ready && r_aout);
            exp_pend = m_valid && m_we && (m_wa != 5'd0) && isLoadOp(m_op) && !ready;
            exp_w    = refData(m_op, m_alu, m_has ? m_data : r_rd);
            checkOutput("rnd_validout", {31'h0, validout}, {31'h0, m_valid && ready});
            checkOutput("rnd_allowin", {31'h0, allowin}, {31'h0, exp_ai});
            checkOutput("rnd_rf_we", {31'h0, output_rf_we}, {31'h0, m_valid && ready && m_we});
            checkOutput("rnd_fwd_valid", {31'h0, fwd_valid},
                        {31'h0, m_valid && m_we && (m_wa != 5'd0)});
            checkOutput("rnd_fwd_pending", {31'h0, fwd_pending}, {31'h0, exp_pend});
            checkOutput("rnd_pc", output_pc, m_pc);
            checkOutput("rnd_waddr", {27'h0, fwd_waddr}, {27'h0, m_wa});
            if (m_valid && ready) begin
                checkOutput("rnd_wdata", output_rf_wdata, exp_w);
                checkOutput("rnd_fwd_wdata", fwd_wdata, exp_w);
            end
            @(posedge clk);
            if (exp_ai) begin
                if (r_vin) begin
                    m_pc = input_pc; m_wa = input_rf_waddr; m_we = input_rf_we;
                    m_alu = input_alu_result; m_mreq = input_mem_req; m_op = input_load_op;
                    m_has = 1'b0;
                end
                m_valid = r_vin;
            end else if (m_valid && m_mreq && !m_has && r_dok) begin
                m_has  = 1'b1;
                m_data = r_rd;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
